// File: rtl/lsu_mem_ctrl.sv
// Initiator side of the LSU data-SRAM handshake: takes one EXU instruction at a time,
// runs the AR/R or AW/W/B sequence for loads and stores, then presents the result to WBU.
module lsu_mem_ctrl #(
    parameter int DATA_W  = 32,
    parameter int RESP_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_pre_i,
    output logic              ready_pre_o,
    input  logic              is_load_i,
    input  logic              is_store_i,
    output logic              arvalid_o,
    input  logic              arready_i,
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [RESP_W-1:0] rresp_i,
    input  logic              rvalid_i,
    output logic              rready_o,
    output logic              awvalid_o,
    input  logic              awready_i,
    output logic              wvalid_o,
    input  logic              wready_i,
    input  logic [RESP_W-1:0] bresp_i,
    input  logic              bvalid_i,
    output logic              bready_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              err_o,
    output logic              valid_post_o,
    input  logic              ready_post_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_AW_W,
        S_B,
        S_DONE
    } state_t;

    localparam logic [31:0] CNT_LAST = 32'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

    state_t      state_q;
    state_t      state_d;
    logic        aw_done_q;
    logic        w_done_q;
    logic [31:0] cnt_q;
    logic        timeout_hit;
    logic        chan_active;

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);
    assign chan_active = (state_q == S_AR) || (state_q == S_R) ||
                         (state_q == S_AW_W) || (state_q == S_B);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A real handshake in the last allowed cycle still wins over the timeout abort.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (valid_pre_i) begin
                    if (is_load_i) begin
                        state_d = S_AR;
                    end else if (is_store_i) begin
                        state_d = S_AW_W;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_AR: begin
                if (arready_i) begin
                    state_d = S_R;
                end else if (timeout_hit) begin
                    state_d = S_DONE;
                end
            end
            S_R: begin
                if (rvalid_i || timeout_hit) begin
                    state_d = S_DONE;
                end
            end
            S_AW_W: begin
                if ((aw_done_q || awready_i) && (w_done_q || wready_i)) begin
                    state_d = S_B;
                end else if (timeout_hit) begin
                    state_d = S_DONE;
                end
            end
            S_B: begin
                if (bvalid_i || timeout_hit) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (ready_post_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ready_pre_o  = 1'b0;
        arvalid_o    = 1'b0;
        rready_o     = 1'b0;
        awvalid_o    = 1'b0;
        wvalid_o     = 1'b0;
        bready_o     = 1'b0;
        valid_post_o = 1'b0;
        case (state_q)
            S_IDLE: ready_pre_o = 1'b1;
            S_AR:   arvalid_o = 1'b1;
            S_R:    rready_o = 1'b1;
            S_AW_W: begin
                awvalid_o = !aw_done_q;
                wvalid_o  = !w_done_q;
            end
            S_B:    bready_o = 1'b1;
            S_DONE: valid_post_o = 1'b1;
            default: ;
        endcase
    end

    // Per-channel done flags only live while we stay in AW_W, so they are fresh on every entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            aw_done_q <= (state_q == S_AW_W) && (state_d == S_AW_W) && (aw_done_q || awready_i);
            w_done_q  <= (state_q == S_AW_W) && (state_d == S_AW_W) && (w_done_q || wready_i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (state_d != state_q) begin
            cnt_q <= '0;
        end else if (chan_active && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    // rdata_o only moves on a load data beat; err_o is cleared on accept and set by response or abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_o <= '0;
            err_o   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (valid_pre_i) begin
                        err_o <= 1'b0;
                    end
                end
                S_AR: begin
                    if (!arready_i && timeout_hit) begin
                        err_o <= 1'b1;
                    end
                end
                S_R: begin
                    if (rvalid_i) begin
                        rdata_o <= rdata_i;
                        err_o   <= (rresp_i != '0);
                    end else if (timeout_hit) begin
                        err_o <= 1'b1;
                    end
                end
                S_AW_W: begin
                    if (state_d == S_DONE) begin
                        err_o <= 1'b1;
                    end
                end
                S_B: begin
                    if (bvalid_i) begin
                        err_o <= (bresp_i != '0);
                    end else if (timeout_hit) begin
                        err_o <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: load/store/non-mem flows, error responses, timeout and reset.
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_pre_i = 1'b0;
    logic        ready_pre_o;
    logic        is_load_i = 1'b0;
    logic        is_store_i = 1'b0;
    logic        arvalid_o;
    logic        arready_i = 1'b0;
    logic [31:0] rdata_i = '0;
    logic [31:0] rresp_i = '0;
    logic        rvalid_i = 1'b0;
    logic        rready_o;
    logic        awvalid_o;
    logic        awready_i = 1'b0;
    logic        wvalid_o;
    logic        wready_i = 1'b0;
    logic [31:0] bresp_i = '0;
    logic        bvalid_i = 1'b0;
    logic        bready_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        valid_post_o;
    logic        ready_post_i = 1'b0;

    int total = 0;
    int bad   = 0;

    lsu_mem_ctrl #(.DATA_W(32), .RESP_W(32), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .valid_pre_i(valid_pre_i), .ready_pre_o(ready_pre_o),
        .is_load_i(is_load_i), .is_store_i(is_store_i),
        .arvalid_o(arvalid_o), .arready_i(arready_i),
        .rdata_i(rdata_i), .rresp_i(rresp_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
        .awvalid_o(awvalid_o), .awready_i(awready_i),
        .wvalid_o(wvalid_o), .wready_i(wready_i),
        .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
        .rdata_o(rdata_o), .err_o(err_o),
        .valid_post_o(valid_post_o), .ready_post_i(ready_post_i)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic vpre, input logic ld, input logic st);
        valid_pre_i = vpre;
        is_load_i   = ld;
        is_store_i  = st;
    endtask

    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic checkWord(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tick();
        tick();
        checkOutput("rst_ready_pre", ready_pre_o, 1'b1);
        checkOutput("rst_valid_post", valid_post_o, 1'b0);
        checkOutput("rst_arvalid", arvalid_o, 1'b0);
        checkOutput("rst_awvalid", awvalid_o, 1'b0);
        checkWord("rst_rdata", rdata_o, 32'h0);
        checkOutput("rst_err", err_o, 1'b0);
        rst = 1'b0;

        // Load with zero-wait SRAM
        applyStimulus(1'b1, 1'b1, 1'b0);
        arready_i = 1'b1;
        rvalid_i  = 1'b1;
        rdata_i   = 32'hDEADBEEF;
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("ld_c1_arvalid", arvalid_o, 1'b1);
        checkOutput("ld_c1_ready_pre", ready_pre_o, 1'b0);
        tick();
        checkOutput("ld_c2_rready", rready_o, 1'b1);
        checkOutput("ld_c2_arvalid", arvalid_o, 1'b0);
        checkOutput("ld_c2_valid_post", valid_post_o, 1'b0);
        tick();
        checkOutput("ld_c3_valid_post", valid_post_o, 1'b1);
        checkWord("ld_c3_rdata", rdata_o, 32'hDEADBEEF);
        checkOutput("ld_c3_err", err_o, 1'b0);
        ready_post_i = 1'b1;
        rdata_i      = 32'h0BADF00D;
        tick();
        ready_post_i = 1'b0;
        checkOutput("ld_idle_ready_pre", ready_pre_o, 1'b1);
        checkOutput("ld_idle_valid_post", valid_post_o, 1'b0);
        tick();
        checkWord("idle_rvalid_ignored", rdata_o, 32'hDEADBEEF);
        checkOutput("idle_stays_idle", ready_pre_o, 1'b1);
        arready_i = 1'b0;
        rvalid_i  = 1'b0;

        // Store with write data accepted two cycles before the address
        applyStimulus(1'b1, 1'b0, 1'b1);
        wready_i = 1'b1;
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("st_c1_awvalid", awvalid_o, 1'b1);
        checkOutput("st_c1_wvalid", wvalid_o, 1'b1);
        tick();
        wready_i = 1'b0;
        checkOutput("st_c2_wvalid_dropped", wvalid_o, 1'b0);
        checkOutput("st_c2_awvalid_held", awvalid_o, 1'b1);
        checkOutput("st_c2_bready", bready_o, 1'b0);
        tick();
        checkOutput("st_c3_awvalid_held", awvalid_o, 1'b1);
        checkOutput("st_c3_bready", bready_o, 1'b0);
        awready_i = 1'b1;
        tick();
        awready_i = 1'b0;
        checkOutput("st_c4_bready", bready_o, 1'b1);
        checkOutput("st_c4_awvalid", awvalid_o, 1'b0);
        bvalid_i = 1'b1;
        tick();
        bvalid_i = 1'b0;
        checkOutput("st_done_valid_post", valid_post_o, 1'b1);
        checkOutput("st_done_err", err_o, 1'b0);
        checkWord("st_rdata_unchanged", rdata_o, 32'hDEADBEEF);
        ready_post_i = 1'b1;
        tick();
        ready_post_i = 1'b0;

        // Load with error response, WBU stalls three cycles
        applyStimulus(1'b1, 1'b1, 1'b0);
        arready_i = 1'b1;
        rvalid_i  = 1'b1;
        rresp_i   = 32'h2;
        rdata_i   = 32'h12345678;
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick();
        tick();
        arready_i = 1'b0;
        rvalid_i  = 1'b0;
        rresp_i   = 32'h0;
        rdata_i   = 32'hFFFFFFFF;
        for (int i = 0; i < 3; i++) begin
            checkOutput("lderr_valid_post", valid_post_o, 1'b1);
            checkOutput("lderr_err", err_o, 1'b1);
            checkWord("lderr_rdata", rdata_o, 32'h12345678);
            tick();
        end
        checkOutput("lderr_still_valid", valid_post_o, 1'b1);
        ready_post_i = 1'b1;
        tick();
        ready_post_i = 1'b0;
        checkOutput("lderr_back_idle", ready_pre_o, 1'b1);

        // Load timeout: address never accepted, eight cycles in AR
        applyStimulus(1'b1, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("to_clear_err", err_o, 1'b0);
        for (int i = 0; i < 8; i++) begin
            checkOutput("to_arvalid_held", arvalid_o, 1'b1);
            checkOutput("to_no_valid_post", valid_post_o, 1'b0);
            if (i < 7) begin
                tick();
            end
        end
        tick();
        checkOutput("to_arvalid_dropped", arvalid_o, 1'b0);
        checkOutput("to_valid_post", valid_post_o, 1'b1);
        checkOutput("to_err", err_o, 1'b1);
        checkWord("to_rdata_unchanged", rdata_o, 32'h12345678);
        ready_post_i = 1'b1;
        tick();
        ready_post_i = 1'b0;

        // Reset pulsed while waiting in B
        applyStimulus(1'b1, 1'b0, 1'b1);
        awready_i = 1'b1;
        wready_i  = 1'b1;
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick();
        awready_i = 1'b0;
        wready_i  = 1'b0;
        checkOutput("rstB_in_B", bready_o, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rstB_bready", bready_o, 1'b0);
        checkOutput("rstB_ready_pre", ready_pre_o, 1'b1);
        checkWord("rstB_rdata", rdata_o, 32'h0);
        rst = 1'b0;
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0);
        arready_i = 1'b1;
        rvalid_i  = 1'b1;
        rdata_i   = 32'hCAFEF00D;
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick();
        tick();
        arready_i = 1'b0;
        rvalid_i  = 1'b0;
        checkOutput("post_rst_valid_post", valid_post_o, 1'b1);
        checkWord("post_rst_rdata", rdata_o, 32'hCAFEF00D);
        checkOutput("post_rst_err", err_o, 1'b0);
        ready_post_i = 1'b1;
        tick();

        // Non-memory instruction passes straight to DONE
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("nm_c1_valid_post", valid_post_o, 1'b1);
        checkOutput("nm_c1_ready_pre", ready_pre_o, 1'b0);
        checkOutput("nm_c1_arvalid", arvalid_o, 1'b0);
        tick();
        checkOutput("nm_c2_ready_pre", ready_pre_o, 1'b1);
        checkOutput("nm_c2_valid_post", valid_post_o, 1'b0);
        ready_post_i = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
